led_pattern_seq: RTL and testbench

- Sequences the board LEDs from the slide switches.
- Synchronises and debounces each switch, then turns switch edges into run/pause and mode-advance commands.
- Generates a programmable step tick and drives one of three LED patterns (walking bit, blink, binary count).
- Sits between the raw switch pins and the LED pins at top level, in place of a direct switch-to-LED mapping.

---
 rtl/led_pattern_seq_if.sv | 30 +++
 rtl/led_pattern_seq.sv | 208 ++++++++++++++++++++
 tb/tb_led_pattern_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// Switch/LED bundle for led_pattern_seq.
//   sw      : raw slide switches (board side drives)
//   led     : LED drive (sequencer drives)
//   mode    : current pattern, 0 = SHIFT, 1 = BLINK, 2 = COUNT
//   running : high while the sequencer is running
interface led_pattern_seq_if #(
    parameter int unsigned SW_NUM  = 3,
    parameter int unsigned LED_NUM = 4
);
    logic [SW_NUM-1:0]  sw;
    logic [LED_NUM-1:0] led;
    logic [1:0]         mode;
    logic               running;

    // Board / pin side
    modport master (
        output sw,
        input  led,
        input  mode,
        input  running
    );

    // Sequencer side
    modport slave (
        input  sw,
        output led,
        output mode,
        output running
    );
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer driven by slide switches.
// Each switch is synchronised (2 FF) and debounced; rising edges of sw[0]
// toggle run/pause, rising edges of sw[1] advance the pattern, and sw[2]
// selects the fast step rate. Patterns: walking bit, blink, binary count.
// Ports:
//   clk         : system clock, rising edge
//   resetn      : asynchronous active-low reset
//   bus.sw      : raw switches, sw[SW_NUM-1:3] ignored
//   bus.led     : LED drive, registered
//   bus.mode    : current pattern, registered
//   bus.running : high in RUN, registered
module led_pattern_seq #(
    parameter int unsigned LED_NUM  = 4,
    parameter int unsigned SW_NUM   = 3,
    parameter int unsigned DB_CYC   = 500000,
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic                clk,
    input  logic                resetn,
    led_pattern_seq_if.slave    bus
);

    localparam int unsigned DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYC - 1);
    localparam logic [TICK_W-1:0] LIM_SLOW = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] LIM_FAST = TICK_W'(TICK_DIV / 2 - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [1:0] MODE_SHIFT = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;

    // Switch conditioning state
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      db_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [1:0]      vld_q;
    logic [1:0]      arm_q;
    logic [1:0]      prev_q;

    // Commands derived from debounced switches
    logic run_ev_c;
    logic mode_ev_c;
    logic fast_c;
    logic tick_c;

    // Sequencer state
    logic [1:0]         state_q,    state_d;
    logic [1:0]         mode_q,     mode_d;
    logic [LED_NUM-1:0] led_q,      led_d;
    logic               running_q,  running_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [TICK_W-1:0]  tick_lim_c;

    // First LED value of a pattern
    function automatic logic [LED_NUM-1:0] led_init(input logic [1:0] m);
        logic [LED_NUM-1:0] v;
        case (m)
            MODE_SHIFT: v = LED_NUM'(1);
            MODE_BLINK: v = '1;
            default:    v = '0;
        endcase
        return v;
    endfunction

    // One pattern step
    function automatic logic [LED_NUM-1:0] led_step(input logic [1:0] m,
                                                     input logic [LED_NUM-1:0] v);
        logic [LED_NUM-1:0] r;
        case (m)
            MODE_SHIFT: r = {v[LED_NUM-2:0], v[LED_NUM-1]};
            MODE_BLINK: r = ~v;
            MODE_COUNT: r = v + LED_NUM'(1);
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Pattern order SHIFT -> BLINK -> COUNT -> SHIFT
    function automatic logic [1:0] mode_next(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            MODE_SHIFT: r = MODE_BLINK;
            MODE_BLINK: r = MODE_COUNT;
            default:    r = MODE_SHIFT;
        endcase
        return r;
    endfunction

    // Synchronise, debounce and arm the edge detectors.
    // A command switch only produces events once it has been seen low after
    // reset, so a switch left high across reset does not restart the sequencer.
    // vld_q marks when the sync chain holds real pin samples again.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            vld_q   <= '0;
            arm_q   <= '0;
            prev_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.sw[2:0];
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            prev_q  <= db_q[1:0];
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (vld_q[1] && !sync2_q[i] && !db_q[i]) begin
                    arm_q[i] <= 1'b1;
                end
            end
        end
    end

    // Rising-edge commands, speed level and step tick
    assign run_ev_c   = db_q[0] & ~prev_q[0] & arm_q[0];
    assign mode_ev_c  = db_q[1] & ~prev_q[1] & arm_q[1];
    assign fast_c     = db_q[2];
    assign tick_lim_c = fast_c ? LIM_FAST : LIM_SLOW;
    // >= so a drop to the fast limit fires at once when already past it
    assign tick_c     = (state_q == ST_RUN) && (tick_cnt_q >= tick_lim_c);

    // Sequencer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SHIFT;
            led_q      <= '0;
            running_q  <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
            running_q  <= running_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Next state, next outputs and step counter
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        led_d      = led_q;
        running_d  = running_q;
        tick_cnt_d = tick_cnt_q;

        if (run_ev_c && mode_ev_c) begin
            // Clear gesture: back to IDLE with LEDs off, pattern kept
            state_d = ST_IDLE;
            led_d   = '0;
        end else if (run_ev_c) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    led_d   = led_init(mode_q);
                end
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default: begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end
            endcase
        end else if (mode_ev_c) begin
            mode_d = mode_next(mode_q);
            if (state_q != ST_IDLE) begin
                led_d = led_init(mode_d);
            end
        end else if (tick_c) begin
            led_d = led_step(mode_q, led_q);
        end

        running_d = (state_d == ST_RUN);

        if ((state_d != state_q) || mode_ev_c) begin
            tick_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        end
    end

    assign bus.led     = led_q;
    assign bus.mode    = mode_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with DB_CYC=4, TICK_DIV=8, LED_NUM=4.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// A switch raised after edge E becomes a command applied on edge E+7.
module tb_led_pattern_seq;

    localparam int unsigned LED_NUM  = 4;
    localparam int unsigned SW_NUM   = 3;
    localparam int unsigned DB_CYC   = 4;
    localparam int unsigned TICK_DIV = 8;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  sw_v   = '0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    int unsigned shift_seq [4] = '{2, 4, 8, 1};
    int unsigned prev_led;

    led_pattern_seq_if #(.SW_NUM(SW_NUM), .LED_NUM(LED_NUM)) bus ();

    assign bus.sw = sw_v;

    led_pattern_seq #(
        .LED_NUM  (LED_NUM),
        .SW_NUM   (SW_NUM),
        .DB_CYC   (DB_CYC),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int unsigned e_led,
                              input int unsigned e_mode, input int unsigned e_run);
        check_val({tag, ".led"},     32'(bus.led),     e_led);
        check_val({tag, ".mode"},    32'(bus.mode),    e_mode);
        check_val({tag, ".running"}, 32'(bus.running), e_run);
    endtask

    initial begin
        // Reset, then idle with switches low
        cyc(3);
        check_outs("reset", 0, 0, 0);
        resetn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            check_outs("idle", 0, 0, 0);
        end

        // 3-cycle glitch on sw[0] is rejected
        sw_v[0] = 1'b1;
        cyc(3);
        sw_v[0] = 1'b0;
        cyc(10);
        check_outs("glitch", 0, 0, 0);

        // Held sw[0]: RUN exactly 7 cycles after the rise
        sw_v[0] = 1'b1;
        cyc(6);
        check_val("run_early", 32'(bus.running), 0);
        cyc(1);
        check_outs("run_start", 1, 0, 1);

        // SHIFT walks every 8 cycles, MSB wraps to LSB
        prev_led = 1;
        for (int k = 0; k < 4; k++) begin
            cyc(7);
            check_val("shift_hold", 32'(bus.led), prev_led);
            cyc(1);
            check_val("shift_step", 32'(bus.led), shift_seq[k]);
            prev_led = shift_seq[k];
        end

        // Mode advance to BLINK
        sw_v[1] = 1'b1;
        cyc(7);
        check_outs("blink_load", 15, 1, 1);
        sw_v[1] = 1'b0;
        cyc(7);
        check_val("blink_hold", 32'(bus.led), 15);
        cyc(1);
        check_val("blink_off", 32'(bus.led), 0);
        cyc(8);
        check_val("blink_on", 32'(bus.led), 15);

        // Mode advance to COUNT, full wrap 15 -> 0
        sw_v[1] = 1'b1;
        cyc(7);
        check_outs("count_load", 0, 2, 1);
        sw_v[1] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc(8);
            check_val("count_step", 32'(bus.led), 32'(k % 16));
        end

        // Fast speed lands with the tick counter at 5: tick next cycle
        cyc(7);
        sw_v[2] = 1'b1;
        cyc(6);
        check_val("fast_pre", 32'(bus.led), 1);
        cyc(1);
        check_val("fast_first", 32'(bus.led), 2);
        cyc(3);
        check_val("fast_hold", 32'(bus.led), 2);
        cyc(1);
        check_val("fast_step1", 32'(bus.led), 3);
        cyc(4);
        check_val("fast_step2", 32'(bus.led), 4);

        // Pause: lower then raise sw[0]
        sw_v[0] = 1'b0;
        cyc(6);
        check_val("pause_lower", 32'(bus.led), 5);
        sw_v[0] = 1'b1;
        cyc(6);
        check_outs("pause_pre", 7, 2, 1);
        cyc(1);
        check_outs("pause", 7, 2, 0);
        cyc(20);
        check_outs("pause_frozen", 7, 2, 0);

        // Resume from the frozen value with a fresh tick count
        sw_v[0] = 1'b0;
        cyc(6);
        sw_v[0] = 1'b1;
        cyc(7);
        check_outs("resume", 7, 2, 1);
        cyc(3);
        check_val("resume_hold", 32'(bus.led), 7);
        cyc(1);
        check_val("resume_step", 32'(bus.led), 8);

        // Clear gesture: sw[0] and sw[1] rise together
        sw_v[0] = 1'b0;
        cyc(6);
        check_val("clear_pre", 32'(bus.led), 9);
        sw_v[0] = 1'b1;
        sw_v[1] = 1'b1;
        cyc(7);
        check_outs("clear", 0, 2, 0);
        cyc(10);
        check_outs("clear_stay", 0, 2, 0);

        // Mode advance in IDLE keeps LEDs off, wraps COUNT -> SHIFT
        sw_v[0] = 1'b0;
        sw_v[1] = 1'b0;
        cyc(6);
        sw_v[1] = 1'b1;
        cyc(7);
        check_outs("idle_mode", 0, 0, 0);
        sw_v[1] = 1'b0;
        cyc(6);

        // Start again in SHIFT, fast still selected
        sw_v[0] = 1'b1;
        cyc(7);
        check_outs("restart", 1, 0, 1);
        cyc(4);
        check_val("restart_step", 32'(bus.led), 2);
        sw_v[1] = 1'b1;
        cyc(7);
        check_outs("pre_rst", 15, 1, 1);
        sw_v[1] = 1'b0;
        cyc(2);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0);
        cyc(2);
        check_outs("rst_hold", 0, 0, 0);
        resetn = 1'b1;

        // sw[0] held across reset must not start the sequencer
        cyc(20);
        check_outs("post_rst", 0, 0, 0);
        sw_v[0] = 1'b0;
        cyc(6);
        sw_v[0] = 1'b1;
        cyc(6);
        check_val("rearm_early", 32'(bus.running), 0);
        cyc(1);
        check_outs("rearm_run", 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
